// File: rtl/baud_tick_ctrl.sv
// Runtime-programmable UART baud-tick generator: oversample tick (s_tick) and bit tick,
// with glitch-free divisor updates applied only at a tick boundary.
module baud_tick_ctrl #(
  parameter int unsigned DIV_W       = 11,
  parameter int unsigned DIV_DEFAULT = 651,
  parameter int unsigned OVS_W       = 4,
  parameter int unsigned OVS         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             resync,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_ack,
  output logic [DIV_W-1:0] div_cur,
  output logic             running,
  output logic             s_tick,
  output logic             bit_tick
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [OVS_W-1:0]   ovs_cnt_q, ovs_cnt_d;
  logic [DIV_W-1:0]   div_cur_q, div_cur_d;
  logic [DIV_W-1:0]   pend_q, pend_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               s_tick_q, s_tick_d;
  logic               bit_tick_q, bit_tick_d;
  logic               running_q, running_d;

  logic [DIV_W-1:0]   div_legal;
  logic               wrap;
  logic               accept;

  assign div_legal = (div_in < DIV_W'(2)) ? DIV_W'(2) : div_in;
  assign wrap      = (cnt_q == div_cur_q - DIV_W'(1));
  assign accept    = div_load && !busy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovs_cnt_d  = ovs_cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    s_tick_d   = 1'b0;
    bit_tick_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        ovs_cnt_d = '0;
        if (accept) begin
          div_cur_d = div_legal;
          ack_d     = 1'b1;
        end
        if (en) state_d = RUN;
      end

      RUN: begin
        if (!en) begin
          state_d   = IDLE;
          cnt_d     = '0;
          ovs_cnt_d = '0;
          busy_d    = 1'b0;
          // Leaving RUN: flush a pending value, or apply a fresh load directly as IDLE would.
          if (busy_q) begin
            div_cur_d = pend_q;
            ack_d     = 1'b1;
          end else if (div_load) begin
            div_cur_d = div_legal;
            ack_d     = 1'b1;
          end
        end else begin
          if (resync) begin
            cnt_d     = '0;
            ovs_cnt_d = '0;
          end else if (wrap) begin
            cnt_d    = '0;
            s_tick_d = 1'b1;
            if (ovs_cnt_q == OVS_W'(OVS - 1)) begin
              ovs_cnt_d  = '0;
              bit_tick_d = 1'b1;
            end else begin
              ovs_cnt_d = ovs_cnt_q + OVS_W'(1);
            end
            if (busy_q) begin
              div_cur_d = pend_q;
              busy_d    = 1'b0;
              ack_d     = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          // accept uses the pre-edge busy, so a wrap-coincident load never lands in the same edge
          if (accept) begin
            pend_d = div_legal;
            busy_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ovs_cnt_q  <= '0;
      div_cur_q  <= DIV_W'(DIV_DEFAULT);
      pend_q     <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      s_tick_q   <= 1'b0;
      bit_tick_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovs_cnt_q  <= ovs_cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      s_tick_q   <= s_tick_d;
      bit_tick_q <= bit_tick_d;
      running_q  <= running_d;
    end
  end

  assign div_busy = busy_q;
  assign div_ack  = ack_q;
  assign div_cur  = div_cur_q;
  assign running  = running_q;
  assign s_tick   = s_tick_q;
  assign bit_tick = bit_tick_q;

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Self-checking bench for baud_tick_ctrl: directed scenarios plus random traffic against a
// period/tick-count reference model.
module tb_baud_tick_ctrl;
  localparam int DW  = 11;
  localparam int DEF = 5;
  localparam int OW  = 4;
  localparam int OVS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          resync;
  logic [DW-1:0] div_in;
  logic          div_load;
  logic          div_busy;
  logic          div_ack;
  logic [DW-1:0] div_cur;
  logic          running;
  logic          s_tick;
  logic          bit_tick;

  baud_tick_ctrl #(
    .DIV_W      (DW),
    .DIV_DEFAULT(DEF),
    .OVS_W      (OW),
    .OVS        (OVS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .resync  (resync),
    .div_in  (div_in),
    .div_load(div_load),
    .div_busy(div_busy),
    .div_ack (div_ack),
    .div_cur (div_cur),
    .running (running),
    .s_tick  (s_tick),
    .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: time elapsed in the current tick period and s_ticks since the last phase restart.
  int m_run, m_el, m_nst, m_div, m_pv, m_pend;
  int e_s, e_b, e_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int legal(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_run = 0; m_el = 0; m_nst = 0; m_div = DEF; m_pv = 0; m_pend = 0;
    e_s = 0; e_b = 0; e_ack = 0;
  endtask

  task automatic model_step();
    int old_pv;
    old_pv = m_pv;
    e_s = 0; e_b = 0; e_ack = 0;
    if (m_run == 0) begin
      if (div_load) begin
        m_div = legal(int'(div_in));
        e_ack = 1;
      end
      if (en) begin
        m_run = 1; m_el = 0; m_nst = 0;
      end
    end else if (!en) begin
      m_run = 0; m_el = 0; m_nst = 0;
      if (old_pv != 0) begin
        m_div = m_pend; m_pv = 0; e_ack = 1;
      end else if (div_load) begin
        m_div = legal(int'(div_in)); e_ack = 1;
      end
    end else begin
      if (resync) begin
        m_el = 0; m_nst = 0;
      end else begin
        m_el++;
        if (m_el == m_div) begin
          m_el = 0;
          e_s = 1;
          m_nst++;
          e_b = (m_nst % OVS == 0) ? 1 : 0;
          if (old_pv != 0) begin
            m_div = m_pend; m_pv = 0; e_ack = 1;
          end
        end
      end
      if (div_load && old_pv == 0) begin
        m_pend = legal(int'(div_in)); m_pv = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("s_tick",   32'(s_tick),   32'(e_s));
    check("bit_tick", 32'(bit_tick), 32'(e_b));
    check("div_ack",  32'(div_ack),  32'(e_ack));
    check("div_busy", 32'(div_busy), 32'(m_pv));
    check("div_cur",  32'(div_cur),  32'(m_div));
    check("running",  32'(running),  32'(m_run));
  endtask

  task automatic cyc(input logic e, input logic r, input logic l, input int d);
    @(negedge clk);
    reset = 1'b0; en = e; resync = r; div_load = l; div_in = DW'(d);
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; resync = 1'b0; div_load = 1'b0; div_in = '0;
    model_reset();
    #3 compare_all();

    // Free-running ticks at the default divisor
    repeat (45) cyc(1, 0, 0, 0);

    // Mid-period divisor change
    for (int k = 0; k < 20 && m_el != 2; k++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 8);
    repeat (30) cyc(1, 0, 0, 0);

    // Second load while busy is dropped
    cyc(1, 0, 1, 6);
    cyc(1, 0, 1, 3);
    repeat (20) cyc(1, 0, 0, 0);

    // IDLE load with illegal divisor, then restore 5
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 5);
    repeat (2) cyc(0, 0, 0, 0);

    // Resync on the wrap cycle
    repeat (12) cyc(1, 0, 0, 0);
    for (int k = 0; k < 20 && m_el != m_div - 1; k++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (25) cyc(1, 0, 0, 0);
    for (int k = 0; k < 20 && m_el != m_div - 1; k++) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 7);
    repeat (12) cyc(1, 0, 0, 0);

    // en low while busy
    for (int k = 0; k < 20 && m_el != 1; k++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 9);
    cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);

    // Asynchronous reset mid-period with a pending update
    repeat (7) cyc(1, 0, 0, 0);
    for (int k = 0; k < 20 && m_el != 1; k++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 11);
    cyc(1, 0, 0, 0);
    @(negedge clk);
    en = 1'b0; resync = 1'b0; div_load = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    repeat (6) cyc(0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic e, r, l;
      e = ($urandom_range(0, 99) < 94);
      r = ($urandom_range(0, 99) < 3);
      l = ($urandom_range(0, 99) < 6);
      cyc(e, r, l, int'($urandom_range(0, 12)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
